// File: rtl/ok_adder_arbiter.sv
// Round-robin arbiter sharing one registered WIDTH-bit adder between N_REQ requesters.
// Responses return one cycle after each grant; a 32-bit status word is exported for a WireOut.
module ok_adder_arbiter #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned WIDTH = 32
) (
   input  logic                   okClk,
   input  logic                   rst_n,
   input  logic                   en,
   input  logic                   clr_stats,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*WIDTH-1:0] a_flat,
   input  logic [N_REQ*WIDTH-1:0] b_flat,
   output logic [N_REQ-1:0]       gnt,
   output logic [N_REQ-1:0]       rsp_valid,
   output logic [WIDTH-1:0]       rsp_data,
   output logic                   rsp_carry,
   output logic                   busy,
   output logic [31:0]            status
);

   localparam int unsigned PW = $clog2(N_REQ);
   localparam logic [PW-1:0] LAST_IDX = PW'(N_REQ - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [PW-1:0]    ptr_q, ptr_d;
   logic [PW-1:0]    last_id_q, last_id_d;
   logic [7:0]       carry_cnt_q, carry_cnt_d;
   logic [7:0]       req_mask_q, req_mask_d;
   logic             stage_valid_q, stage_valid_d;
   logic [PW-1:0]    stage_id_q, stage_id_d;
   logic [WIDTH-1:0] stage_sum_q, stage_sum_d;
   logic             stage_carry_q, stage_carry_d;

   logic             grant_any;
   logic [PW-1:0]    grant_idx;
   logic [PW-1:0]    pos_w;
   int unsigned      pos;
   logic [WIDTH-1:0] a_sel, b_sel;
   logic [WIDTH:0]   sum_full;

   // Rotating search: the first requester at or after ptr (mod N_REQ) wins.
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      pos       = 0;
      pos_w     = '0;
      if (state_q == ST_RUN && en) begin
         for (int unsigned k = 0; k < N_REQ; k++) begin
            pos = 32'(ptr_q) + k;
            if (pos >= N_REQ) begin
               pos = pos - N_REQ;
            end
            pos_w = pos[PW-1:0];
            if (!grant_any && req[pos_w]) begin
               grant_any = 1'b1;
               grant_idx = pos_w;
            end
         end
      end
   end

   always_comb begin
      a_sel = '0;
      b_sel = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (grant_idx == PW'(i)) begin
            a_sel = a_flat[i*WIDTH +: WIDTH];
            b_sel = b_flat[i*WIDTH +: WIDTH];
         end
      end
      sum_full = {1'b0, a_sel} + {1'b0, b_sel};
   end

   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      last_id_d     = last_id_q;
      stage_valid_d = grant_any;
      stage_id_d    = stage_id_q;
      stage_sum_d   = stage_sum_q;
      stage_carry_d = stage_carry_q;
      req_mask_d    = 8'(req);
      carry_cnt_d   = carry_cnt_q;

      if (grant_any) begin
         ptr_d         = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
         last_id_d     = grant_idx;
         stage_id_d    = grant_idx;
         stage_sum_d   = sum_full[WIDTH-1:0];
         stage_carry_d = sum_full[WIDTH];
      end

      // Clear takes priority over a coincident carry event.
      if (clr_stats) begin
         carry_cnt_d = '0;
      end else if (stage_valid_q && stage_carry_q && carry_cnt_q != 8'hFF) begin
         carry_cnt_d = carry_cnt_q + 8'd1;
      end

      case (state_q)
         ST_IDLE:  if (en) state_d = ST_RUN;
         ST_RUN:   if (!en) state_d = (stage_valid_q || grant_any) ? ST_DRAIN : ST_IDLE;
         ST_DRAIN: if (!stage_valid_q) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge okClk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         ptr_q         <= '0;
         last_id_q     <= '0;
         carry_cnt_q   <= '0;
         req_mask_q    <= '0;
         stage_valid_q <= 1'b0;
         stage_id_q    <= '0;
         stage_sum_q   <= '0;
         stage_carry_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         last_id_q     <= last_id_d;
         carry_cnt_q   <= carry_cnt_d;
         req_mask_q    <= req_mask_d;
         stage_valid_q <= stage_valid_d;
         stage_id_q    <= stage_id_d;
         stage_sum_q   <= stage_sum_d;
         stage_carry_q <= stage_carry_d;
      end
   end

   always_comb begin
      gnt       = '0;
      rsp_valid = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (grant_any && grant_idx == PW'(i)) gnt[i] = 1'b1;
         if (stage_valid_q && stage_id_q == PW'(i)) rsp_valid[i] = 1'b1;
      end
      rsp_data  = stage_sum_q;
      rsp_carry = stage_carry_q;
      busy      = (state_q != ST_IDLE) || stage_valid_q;
      status    = {state_q, 6'b0, req_mask_q, carry_cnt_q, 8'(last_id_q)};
   end

endmodule
